// File: rtl/imem_loader_pkg.sv
// Shared encodings for the instruction-memory loader: FSM states and word geometry.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

endpackage : imem_loader_pkg

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: byte k of each word lands in bits [8k+7:8k].
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              accept_i,
  input  logic              clear_i,
  input  logic [7:0]        data_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_o
);

  logic [BYTE_CNT_W-1:0] cnt_q;
  logic [WORD_W-1:0]     word_q;

  // word_full_o flags the accept that completes the current word.
  assign word_full_o = accept_i && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign word_o      = word_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (accept_i) begin
      word_q[{cnt_q, 3'b000} +: 8] <= data_i;
      cnt_q                        <= cnt_q + 1'b1;
    end
  end

endmodule : byte_packer

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory as consecutive words from address 0 and
// holds the core in reset until a complete image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              we,
  output logic [31:0]       waddr,
  output logic [WORD_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum,
  output logic              core_rst
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] idx_q;
  logic              s_ready_q, we_q, busy_q, done_q, core_rst_q;
  logic [31:0]       waddr_q, checksum_q;

  logic              accept, pack_clear, word_full, last_word;
  logic [WORD_W-1:0] word;

  assign accept     = s_valid && s_ready_q;
  assign pack_clear = (state_q == ST_IDLE) && start && (len_words != '0);
  assign last_word  = ({1'b0, idx_q} == (len_q - 1'b1));

  byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .accept_i    (accept),
    .clear_i     (pack_clear),
    .data_i      (s_data),
    .word_o      (word),
    .word_full_o (word_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      s_ready_q  <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      checksum_q <= '0;
      core_rst_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (len_words == '0) begin
              done_q     <= 1'b1;
              core_rst_q <= 1'b1;
            end else begin
              len_q      <= (len_words > MAX_LEN) ? MAX_LEN : len_words;
              idx_q      <= '0;
              checksum_q <= '0;
              done_q     <= 1'b0;
              core_rst_q <= 1'b0;
              busy_q     <= 1'b1;
              s_ready_q  <= 1'b1;
              state_q    <= ST_RECV;
            end
          end
        end
        ST_RECV: begin
          if (word_full) begin
            s_ready_q <= 1'b0;
            we_q      <= 1'b1;
            waddr_q   <= 32'(idx_q) << 2;
            state_q   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          we_q       <= 1'b0;
          checksum_q <= checksum_q ^ word;
          idx_q      <= idx_q + 1'b1;
          if (last_word) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            core_rst_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            s_ready_q <= 1'b1;
            state_q   <= ST_RECV;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready  = s_ready_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = word;
  assign busy     = busy_q;
  assign done     = done_q;
  assign checksum = checksum_q;
  assign core_rst = core_rst_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load sequences with hand-computed words and checksums.
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len_words = '0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = '0;
  logic              s_ready, we, busy, done, core_rst;
  logic [31:0]       waddr, wdata, checksum;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len_words (len_words),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .core_rst  (core_rst)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int busy_cnt = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      wr_addr.push_back(waddr);
      wr_data.push_back(wdata);
      wr_cyc.push_back(cyc);
    end
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [ADDR_W:0] n);
    @(negedge clk);
    start = 1'b1;
    len_words = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    logic ok;
    int   n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      acc = s_ready;
      @(posedge clk);
      if (acc) ok = 1'b1;
      else @(negedge clk);
      n++;
    end
    #1 s_valid = 1'b0;
    check("byte_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit random_gaps);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], random_gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("load_finishes", 32'(busy), 32'd0);
  endtask

  logic [31:0] words3 [3];
  int base;
  int bc;

  initial begin
    words3[0] = 32'hDEADBEEF;
    words3[1] = 32'h12345678;
    words3[2] = 32'h00A0B0C0;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check("rst_core_rst", 32'(core_rst), 32'd0);
    check("rst_s_ready",  32'(s_ready),  32'd0);
    check("rst_we",       32'(we),       32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_waddr",    waddr,         32'd0);
    check("rst_wdata",    wdata,         32'd0);
    check("rst_checksum", checksum,      32'd0);

    // Idle without start: nothing moves.
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_core_rst", 32'(core_rst), 32'd0);
    check("idle_s_ready",  32'(s_ready),  32'd0);
    check("idle_done",     32'(done),     32'd0);
    check("idle_writes",   32'(wr_addr.size()), 32'd0);
    check("idle_busy_cnt", 32'(busy_cnt), 32'd0);

    // Zero-length load completes immediately without writes or busy.
    bc = busy_cnt;
    do_start('0);
    check("zero_done",     32'(done),     32'd1);
    check("zero_core_rst", 32'(core_rst), 32'd1);
    check("zero_busy",     32'(busy),     32'd0);
    repeat (5) @(negedge clk);
    check("zero_busy_seen", 32'(busy_cnt - bc), 32'd0);
    check("zero_writes",    32'(wr_addr.size()), 32'd0);

    // Single word with exact cycle timing.
    base = wr_addr.size();
    do_start(11'd1);
    check("w1_busy_after_start",   32'(busy),     32'd1);
    check("w1_ready_after_start",  32'(s_ready),  32'd1);
    check("w1_done_cleared",       32'(done),     32'd0);
    check("w1_core_rst_low",       32'(core_rst), 32'd0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    check("w1_we",       32'(we),      32'd1);
    check("w1_ready_lo", 32'(s_ready), 32'd0);
    check("w1_waddr",    waddr,        32'h0);
    check("w1_wdata",    wdata,        32'h00000013);
    check("w1_core_rst_during_write", 32'(core_rst), 32'd0);
    @(negedge clk);
    check("w1_we_drop",   32'(we),       32'd0);
    check("w1_busy_drop", 32'(busy),     32'd0);
    check("w1_done",      32'(done),     32'd1);
    check("w1_core_rst",  32'(core_rst), 32'd1);
    check("w1_checksum",  checksum,      32'h00000013);
    check("w1_writes",    32'(wr_addr.size() - base), 32'd1);

    // Three words with random source gaps.
    base = wr_addr.size();
    do_start(11'd3);
    check("w3_core_rst_low", 32'(core_rst), 32'd0);
    for (int k = 0; k < 3; k++) send_word(words3[k], 1'b1);
    wait_idle();
    check("w3_writes", 32'(wr_addr.size() - base), 32'd3);
    if (wr_addr.size() - base == 3) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("w3_addr%0d", k), wr_addr[base+k], 32'(4 * k));
        check($sformatf("w3_data%0d", k), wr_data[base+k], words3[k]);
        if (k > 0)
          check($sformatf("w3_spacing%0d", k),
                32'(wr_cyc[base+k] - wr_cyc[base+k-1] >= 5), 32'd1);
      end
    end
    check("w3_checksum", checksum,      32'hCC395857);
    check("w3_done",     32'(done),     32'd1);
    check("w3_core_rst", 32'(core_rst), 32'd1);

    // Starts during RECV and during WRITE are ignored.
    base = wr_addr.size();
    do_start(11'd2);
    send_byte(8'h44, 0);
    send_byte(8'h33, 0);
    do_start(11'd5);
    send_byte(8'h22, 0);
    send_byte(8'h11, 0);
    do_start(11'd5);
    send_word(32'h55667788, 1'b0);
    wait_idle();
    check("sb_writes", 32'(wr_addr.size() - base), 32'd2);
    if (wr_addr.size() - base == 2) begin
      check("sb_addr0", wr_addr[base],   32'h0);
      check("sb_data0", wr_data[base],   32'h11223344);
      check("sb_addr1", wr_addr[base+1], 32'h4);
      check("sb_data1", wr_data[base+1], 32'h55667788);
      check("sb_spacing_min", 32'(wr_cyc[base+1] - wr_cyc[base]), 32'd5);
    end
    check("sb_checksum", checksum,      32'h444444CC);
    check("sb_core_rst", 32'(core_rst), 32'd1);
    repeat (10) @(negedge clk);
    check("sb_stays_idle",    32'(s_ready), 32'd0);
    check("sb_no_extra_write", 32'(wr_addr.size() - base), 32'd2);

    // Reset in the middle of the second word.
    base = wr_addr.size();
    do_start(11'd2);
    send_word(32'hAABBCCDD, 1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mr_we",       32'(we),       32'd0);
    check("mr_s_ready",  32'(s_ready),  32'd0);
    check("mr_busy",     32'(busy),     32'd0);
    check("mr_done",     32'(done),     32'd0);
    check("mr_core_rst", 32'(core_rst), 32'd0);
    check("mr_waddr",    waddr,         32'd0);
    check("mr_wdata",    wdata,         32'd0);
    check("mr_checksum", checksum,      32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("mr_writes", 32'(wr_addr.size() - base), 32'd1);
    if (wr_addr.size() - base >= 1) check("mr_first_word", wr_data[base], 32'hAABBCCDD);
    check("mr_core_rst_held", 32'(core_rst), 32'd0);

    base = wr_addr.size();
    do_start(11'd1);
    send_word(32'h00500093, 1'b0);
    wait_idle();
    check("ar_writes", 32'(wr_addr.size() - base), 32'd1);
    if (wr_addr.size() - base == 1) begin
      check("ar_addr", wr_addr[base], 32'h0);
      check("ar_data", wr_data[base], 32'h00500093);
    end
    check("ar_checksum", checksum,      32'h00500093);
    check("ar_done",     32'(done),     32'd1);
    check("ar_core_rst", 32'(core_rst), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_imem_loader
